// File: rtl/lsu.sv
// Load/store unit: maps byte-addressed word/half/byte requests onto a word-wide
// synchronous RAM, with read-modify-write for sub-word stores.
module lsu #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_wr,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_misalign,
    output logic                  o_ram_we,
    output logic                  o_ram_oe,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [31:0]           o_ram_data,
    input  logic [31:0]           i_ram_data
);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_e;

    state_e                state, state_nxt;
    size_e                 req_size;
    logic                  req_wr, req_unsigned;
    logic [1:0]            req_lane;
    logic [15:0]           req_wdata;

    logic                  accept, fault;
    logic [31:0]           rdata_nxt, ram_data_nxt;
    logic [ADDR_WIDTH-1:0] ram_addr_nxt;
    logic                  done_nxt, misalign_nxt, we_nxt, oe_nxt;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [31:0]           load_val, merged;

    // Address bits above the RAM range wrap and are intentionally unused.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH+2];

    assign o_busy = (state != IDLE);
    assign accept = (state == IDLE) && i_req;
    assign fault  = (i_size == SZ_BAD)
                 || ((i_size == SZ_HALF) && i_addr[0])
                 || ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    always_comb begin
        sel_byte = i_ram_data[{req_lane, 3'b000} +: 8];
        sel_half = req_lane[1] ? i_ram_data[31:16] : i_ram_data[15:0];
        case (req_size)
            SZ_BYTE: load_val = {{24{~req_unsigned & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_val = {{16{~req_unsigned & sel_half[15]}}, sel_half};
            default: load_val = i_ram_data;
        endcase
        merged = i_ram_data;
        if (req_size == SZ_BYTE)
            merged[{req_lane, 3'b000} +: 8] = req_wdata[7:0];
        else if (req_lane[1])
            merged[31:16] = req_wdata;
        else
            merged[15:0] = req_wdata;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt    = state;
        rdata_nxt    = o_rdata;
        ram_addr_nxt = o_ram_addr;
        ram_data_nxt = o_ram_data;
        done_nxt     = 1'b0;
        misalign_nxt = 1'b0;
        we_nxt       = 1'b0;
        oe_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault) begin
                        done_nxt     = 1'b1;
                        misalign_nxt = 1'b1;
                    end else begin
                        ram_addr_nxt = i_addr[ADDR_WIDTH+1:2];
                        if (i_wr && (i_size == SZ_WORD)) begin
                            state_nxt    = WR;
                            we_nxt       = 1'b1;
                            ram_data_nxt = i_wdata;
                        end else begin
                            state_nxt = RD;
                            oe_nxt    = 1'b1;
                        end
                    end
                end
            end
            RD:  state_nxt = CAP;
            CAP: begin
                if (req_wr) begin
                    state_nxt    = WR;
                    we_nxt       = 1'b1;
                    ram_data_nxt = merged;
                end else begin
                    state_nxt = IDLE;
                    rdata_nxt = load_val;
                    done_nxt  = 1'b1;
                end
            end
            WR: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            o_rdata      <= '0;
            o_ram_addr   <= '0;
            o_ram_data   <= '0;
            o_done       <= 1'b0;
            o_misalign   <= 1'b0;
            o_ram_we     <= 1'b0;
            o_ram_oe     <= 1'b0;
            req_size     <= SZ_BYTE;
            req_wr       <= 1'b0;
            req_unsigned <= 1'b0;
            req_lane     <= 2'b00;
            req_wdata    <= '0;
        end else begin
            state      <= state_nxt;
            o_rdata    <= rdata_nxt;
            o_ram_addr <= ram_addr_nxt;
            o_ram_data <= ram_data_nxt;
            o_done     <= done_nxt;
            o_misalign <= misalign_nxt;
            o_ram_we   <= we_nxt;
            o_ram_oe   <= oe_nxt;
            if (accept) begin
                req_size     <= size_e'(i_size);
                req_wr       <= i_wr;
                req_unsigned <= i_unsigned;
                req_lane     <= i_addr[1:0];
                req_wdata    <= i_wdata[15:0];
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: drives the core side and models the synchronous data RAM.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        busy, done, misalign, ram_we, ram_oe;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [0:255];
    int total = 0;
    int bad   = 0;
    int both_strobes = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata),
        .o_busy(busy), .o_done(done), .o_misalign(misalign),
        .o_ram_we(ram_we), .o_ram_oe(ram_oe), .o_ram_addr(ram_addr),
        .o_ram_data(ram_wdata), .i_ram_data(ram_rdata)
    );

    // NOTE: the RAM array has no reset; its contents are established by stores.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (ram_oe) ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) if (ram_we && ram_oe) both_strobes++;

    // Issues one request at a negedge and follows it until o_done (12-cycle budget).
    task automatic do_op(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int cyc, output int busy_n, output logic mis,
                         output logic saw_we, output logic saw_oe, output logic [7:0] st_addr);
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = d;
        cyc = 0; busy_n = 0; mis = 1'b0; saw_we = 1'b0; saw_oe = 1'b0; st_addr = 8'hFF;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (busy) busy_n++;
            if (ram_oe) begin saw_oe = 1'b1; st_addr = ram_addr; end
            if (ram_we) begin saw_we = 1'b1; st_addr = ram_addr; end
            if (done) begin cyc = k; mis = misalign; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
        #1;
        total++;
        if ({busy, done, misalign, ram_we, ram_oe} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=00000", {busy, done, misalign, ram_we, ram_oe});
        end
        total++;
        if ({rdata, ram_wdata, ram_addr} !== 72'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h want=0", rdata, ram_wdata, ram_addr);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_store_load();
        int c, b; logic m, sw, so; logic [7:0] sa;
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, c, b, m, sw, so, sa);
        total++;
        if (c !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", c); end
        total++;
        if ({sw, so, m, sa} !== {3'b100, 8'd4}) begin
            bad++; $display("FAIL sw_strobe got we=%b oe=%b mis=%b a=%0d want we=1 oe=0 mis=0 a=4", sw, so, m, sa);
        end
        total++;
        if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h want=deadbeef", mem[4]); end
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, c, b, m, sw, so, sa);
        total++;
        if ({c, b} !== {32'd3, 32'd2}) begin bad++; $display("FAIL lw_latency got=%0d/%0d want=3/2", c, b); end
        total++;
        if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", rdata); end
    endtask

    task automatic test_subword_store();
        int c, b; logic m, sw, so; logic [7:0] sa;
        do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, c, b, m, sw, so, sa);
        do_op(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA, c, b, m, sw, so, sa);
        total++;
        if ({c, b} !== {32'd4, 32'd3}) begin bad++; $display("FAIL sb_timing got=%0d/%0d want=4/3", c, b); end
        total++;
        if (mem[8] !== 32'h1122AA44) begin bad++; $display("FAIL sb_mem got=%h want=1122aa44", mem[8]); end
        do_op(1'b1, 2'b01, 1'b0, 32'h22, 32'h12345566, c, b, m, sw, so, sa);
        total++;
        if ({c, b, sa} !== {32'd4, 32'd3, 8'd8}) begin bad++; $display("FAIL sh_timing got=%0d/%0d a=%0d want=4/3 a=8", c, b, sa); end
        total++;
        if (mem[8] !== 32'h5566AA44) begin bad++; $display("FAIL sh_mem got=%h want=5566aa44", mem[8]); end
    endtask

    task automatic test_extension();
        int c, b; logic m, sw, so; logic [7:0] sa;
        logic [31:0] exp_v [5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F0, 32'h00007F01, 32'h0000007F};
        logic [31:0] ad_v  [5]  = '{32'h33, 32'h33, 32'h32, 32'h30, 32'h31};
        logic [1:0]  sz_v  [5]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        u_v   [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_op(1'b1, 2'b10, 1'b0, 32'h30, 32'h80F07F01, c, b, m, sw, so, sa);
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, sz_v[i], u_v[i], ad_v[i], 32'h0, c, b, m, sw, so, sa);
            total++;
            if (rdata !== exp_v[i] || c !== 3) begin
                bad++; $display("FAIL ext_%0d got=%h cyc=%0d want=%h cyc=3", i, rdata, c, exp_v[i]);
            end
        end
    endtask

    task automatic test_faults();
        int c, b; logic m, sw, so; logic [7:0] sa;
        logic        w_v  [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz_v [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad_v [3] = '{32'h22, 32'h23, 32'h20};
        do_op(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, c, b, m, sw, so, sa);
        total++;
        if (m !== 1'b0) begin bad++; $display("FAIL good_no_misalign got=%b want=0", m); end
        for (int i = 0; i < 3; i++) begin
            do_op(w_v[i], sz_v[i], 1'b0, ad_v[i], 32'hFFFF_FFFF, c, b, m, sw, so, sa);
            total++;
            if ({c, b, m, sw, so} !== {32'd1, 32'd0, 3'b100} || rdata !== 32'h80F07F01) begin
                bad++; $display("FAIL fault_%0d got cyc=%0d busy=%0d mis=%b we=%b oe=%b rd=%h want 1/0/1/0/0 rd=80f07f01",
                                i, c, b, m, sw, so, rdata);
            end
        end
        total++;
        if (mem[8] !== 32'h5566AA44) begin bad++; $display("FAIL fault_mem got=%h want=5566aa44", mem[8]); end
    endtask

    task automatic test_back_to_back();
        int c, b; logic m, sw, so; logic [7:0] sa;
        logic [8:1] dmask;
        int oe_n;
        // Load with i_req held: ignored while busy, re-accepted in the o_done cycle.
        @(negedge clk);
        req = 1'b1; wr = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10;
        dmask = '0; oe_n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            dmask[k] = done;
            if (ram_oe) oe_n++;
            if (k == 3) req = 1'b1;
            if (k >= 4) req = 1'b0;
        end
        total++;
        if ({dmask, oe_n[7:0]} !== {8'b0010_0100, 8'd2}) begin
            bad++; $display("FAIL b2b_load done=%b oe=%0d want=00100100 oe=2", dmask, oe_n);
        end
        // Word stores back to back every 2 cycles.
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hDEADBEEF;
        dmask = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            dmask[k] = done;
            if (k >= 3) req = 1'b0;
        end
        total++;
        if (dmask[6:1] !== 6'b001010) begin bad++; $display("FAIL b2b_store done=%b want=001010", dmask[6:1]); end
        // Address wrap: 0x400 maps to word 0.
        do_op(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, c, b, m, sw, so, sa);
        total++;
        if (sa !== 8'd0 || mem[0] !== 32'hCAFEF00D) begin
            bad++; $display("FAIL wrap got a=%0d mem0=%h want a=0 mem0=cafef00d", sa, mem[0]);
        end
    endtask

    task automatic test_reset_mid();
        int c, b; logic m, sw, so; logic [7:0] sa;
        int done_n, we_n;
        do_op(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, c, b, m, sw, so, sa);
        do_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, c, b, m, sw, so, sa);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h41; wdata = 32'h99;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, ram_we, ram_oe} !== 4'b0 || {rdata, ram_wdata, ram_addr} !== 72'h0) begin
            bad++; $display("FAIL mid_reset got busy=%b done=%b we=%b oe=%b rd=%h wd=%h a=%h want all 0",
                            busy, done, ram_we, ram_oe, rdata, ram_wdata, ram_addr);
        end
        done_n = 0; we_n = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) done_n++;
            if (ram_we) we_n++;
        end
        total++;
        if (done_n !== 0 || we_n !== 0 || mem[16] !== 32'h12345678) begin
            bad++; $display("FAIL mid_reset_after done=%0d we=%0d mem=%h want 0/0/12345678", done_n, we_n, mem[16]);
        end
        total++;
        if (both_strobes !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", both_strobes); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_extension();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the MIPS core's memory stage and the synchronous data `ram` (one-cycle registered read; write has priority over read). It turns byte-addressed word, halfword and byte requests into word-wide RAM accesses. Sub-word stores use read-modify-write. Loads are lane-extracted and sign- or zero-extended. The core stalls on `o_busy` until `o_done` pulses.

## Interface
- `ADDR_WIDTH`, 8, RAM word-address width; RAM holds 2^ADDR_WIDTH 32-bit words.
- `i_clk` in 1: the single clock; every flop is rising-edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_req` in 1: request strobe; sampled only in IDLE.
- `i_wr` in 1: 1 = store, 0 = load.
- `i_size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `i_unsigned` in 1: load zero-extends (lbu/lhu) instead of sign-extending.
- `i_addr` in 32: byte address, little-endian.
  - Lane = `i_addr[1:0]`.
  - Word address = `i_addr[ADDR_WIDTH+1:2]`; higher bits are ignored (wrap).
- `i_wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `o_rdata` out 32: extended load result.
  - Registered.
  - Updated only when a load completes; held otherwise.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_done` out 1: one-cycle completion pulse.
- `o_misalign` out 1: one-cycle pulse, coincident with `o_done`, for an illegal or misaligned request.
- `o_ram_we`, `o_ram_oe` out 1: RAM strobes.
  - Registered.
  - Never both high.
- `o_ram_addr` out ADDR_WIDTH: registered word address.
- `o_ram_data` out 32: registered merged write word.
- `i_ram_data` in 32: RAM read port.

## Operation
- States: IDLE, RD, CAP, WR. Request fields are latched when a request is accepted in IDLE.
- Fault check, applied on acceptance:
  - Fault conditions: size 11; halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
  - On a fault: stay in IDLE, pulse `o_done` and `o_misalign` the next cycle, make no RAM access, leave `o_rdata` unchanged.
- Load: IDLE → RD (`o_ram_oe`=1) → CAP (capture `i_ram_data`) → IDLE.
  - Byte selects bits [8·lane+7 : 8·lane].
  - Halfword selects [31:16] if `addr[1]`, else [15:0].
  - Word passes through unchanged.
  - Extend from the selected MSB unless `i_unsigned`.
- Word store: IDLE → WR (`o_ram_we`=1, `o_ram_data`=`i_wdata`) → IDLE.
- Sub-word store: IDLE → RD → CAP → WR → IDLE.
  - In CAP, merge the low byte or half of `i_wdata` into the captured word at the lane.
  - All other bytes are preserved.
- `o_ram_addr` is constant from acceptance to completion.
- `i_req` while busy is ignored; it is not queued.
- `i_req` in the same cycle that `o_done` is high is accepted, because the state is already IDLE.

## Timing
- Request sampled at edge E0.
  - Fault: `o_done` high in cycle E0–E1.
  - Word store: `o_ram_we` high E0–E1; RAM writes at E1; `o_done` high E1–E2.
  - Load: `o_ram_oe` high E0–E1; RAM reads at E1; LSU captures at E2; `o_rdata` valid and `o_done` high E2–E3.
  - Sub-word store: `o_ram_we` high E2–E3; `o_done` high E3–E4.
- `o_busy` is high for exactly the cycles between acceptance and the `o_done` cycle, exclusive of the `o_done` cycle.
- Reset values:
  - State = IDLE.
  - `o_rdata`, `o_ram_addr`, `o_ram_data` = 0.
  - `o_busy`, `o_done`, `o_misalign`, `o_ram_we`, `o_ram_oe` = 0.
- Reset mid-operation: abort immediately (asynchronously).
  - Strobes drop with no `o_done`.
  - A read-modify-write aborted before WR leaves RAM unmodified.
- Throughput: back-to-back word stores complete every 2 cycles, loads every 3, sub-word stores every 4.

## Test plan
- Word store then load: store 0xDEADBEEF to addr 0x10; load word from 0x10.
  - `o_ram_we` at word addr 4.
  - `o_done` 2 cycles after request.
  - `o_rdata`=0xDEADBEEF 3 cycles after the load request.
- Sub-word stores: word 0x11223344 at 0x20, then sb 0xAA at 0x21, then sh 0x5566 at 0x22.
  - Final word = 0x5566AA44.
  - Each sub-word store has `o_busy` high 3 cycles and `o_done` on cycle 4.
- Extension: memory word 0x80F07F01.
  - lb at lane 3 → 0xFFFFFF80.
  - lbu at lane 3 → 0x00000080.
  - lh at 0x..2 → 0xFFFF80F0.
  - lhu at 0x..0 → 0x00007F01.
- Faults: each of the following gives `o_done`+`o_misalign` the next cycle, no strobe, and `o_rdata` unchanged.
  - lw at 0x22.
  - sh at 0x23.
  - size=11.
- Busy/back-to-back and wrap:
  - `i_req` held during a load is ignored until `o_done`.
  - A request in the `o_done` cycle is accepted.
  - addr 0x400 with ADDR_WIDTH=8 wraps to word 0.
- Reset: assert `i_rst` in CAP of an sb.
  - Outputs go to 0 immediately.
  - No `o_done`.
  - Target RAM word unchanged.
